exec_stage: RTL and testbench

- Execute/writeback stage for the 16-bit, 8-register datapath.
- Consumes the two read operands produced by the register bank, computes a 16-bit ALU result, and drives the bank's write port (wr_en/wr_reg/wr_data).
- Single-cycle ops issue back-to-back. The multiply op is iterative and stalls issue through a valid/ready handshake.

---
 rtl/exec_stage.sv | 217 +++++++++++++++++++++
 tb/tb_exec_stage.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_stage.sv
// Execute/writeback stage for the 16-bit, 8-register datapath: single-cycle ALU ops plus an
// optional iterative shift-add multiplier enabled by defining EXEC_MUL_EN.
module exec_stage #(
    parameter  int unsigned MUL_CYCLES = 16,
    localparam int unsigned DW         = 16,
    localparam int unsigned RW         = 3,
    localparam int unsigned OW         = 4,
    localparam int unsigned SW         = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          issue_valid,
    output logic          issue_ready,
    input  logic [OW-1:0] opcode,
    input  logic [RW-1:0] dst_reg,
    input  logic [DW-1:0] op_a,
    input  logic [DW-1:0] op_b,
    output logic          wr_en,
    output logic [RW-1:0] wr_reg,
    output logic [DW-1:0] wr_data,
    output logic          flag_z,
    output logic          flag_c,
    output logic          illegal
);

    localparam logic [OW-1:0] OP_ADD  = 4'd0;
    localparam logic [OW-1:0] OP_SUB  = 4'd1;
    localparam logic [OW-1:0] OP_AND  = 4'd2;
    localparam logic [OW-1:0] OP_OR   = 4'd3;
    localparam logic [OW-1:0] OP_XOR  = 4'd4;
    localparam logic [OW-1:0] OP_SLL  = 4'd5;
    localparam logic [OW-1:0] OP_SRL  = 4'd6;
    localparam logic [OW-1:0] OP_PASS = 4'd8;

    // The multiplier retires exactly one multiplier bit per iteration.
    if (MUL_CYCLES != DW) begin : g_mul_cycles_check
        $error("exec_stage: MUL_CYCLES must equal the data width");
    end

    logic          issue_ready_q, issue_ready_d;
    logic          wr_en_q, wr_en_d;
    logic [RW-1:0] wr_reg_q, wr_reg_d;
    logic [DW-1:0] wr_data_q, wr_data_d;
    logic          flag_z_q, flag_z_d;
    logic          flag_c_q, flag_c_d;
    logic          illegal_q, illegal_d;

    logic          accept;
    logic [DW:0]   sum;
    logic [DW-1:0] alu_res;
    logic          alu_c;
    logic          alu_legal;

    logic          commit;
    logic [DW-1:0] commit_res;
    logic          commit_c;
    logic [RW-1:0] commit_dst;

`ifdef EXEC_MUL_EN
    localparam logic [OW-1:0] OP_MUL = 4'd7;
    localparam int unsigned   CW     = 4;

    typedef enum logic {ST_IDLE, ST_MUL} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] mcand_q, mcand_d;
    logic [DW-1:0] mplier_q, mplier_d;
    logic [DW-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] mdst_q, mdst_d;
    logic [DW-1:0] partial;
`endif

    assign accept = issue_valid && issue_ready_q;

    // Single-cycle ALU; opcode 7 is intercepted by the multiplier when it is built.
    always_comb begin
        sum       = {1'b0, op_a} + {1'b0, op_b};
        alu_res   = '0;
        alu_c     = 1'b0;
        alu_legal = 1'b1;
        case (opcode)
            OP_ADD:  begin
                alu_res = sum[DW-1:0];
                alu_c   = sum[DW];
            end
            OP_SUB:  begin
                alu_res = op_a - op_b;
                alu_c   = (op_a < op_b);
            end
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_SLL:  alu_res = op_a << op_b[SW-1:0];
            OP_SRL:  alu_res = op_a >> op_b[SW-1:0];
            OP_PASS: alu_res = op_b;
            default: alu_legal = 1'b0;
        endcase
    end

    // Issue control, multiplier sequencing and writeback/flag update.
    always_comb begin
        issue_ready_d = 1'b1;
        wr_en_d       = 1'b0;
        wr_reg_d      = wr_reg_q;
        wr_data_d     = wr_data_q;
        flag_z_d      = flag_z_q;
        flag_c_d      = flag_c_q;
        illegal_d     = 1'b0;
        commit        = 1'b0;
        commit_res    = alu_res;
        commit_c      = alu_c;
        commit_dst    = dst_reg;
`ifdef EXEC_MUL_EN
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        mdst_d   = mdst_q;
        partial  = mplier_q[0] ? mcand_q : '0;
`endif

        if (accept) begin
`ifdef EXEC_MUL_EN
            if (opcode == OP_MUL) begin
                state_d       = ST_MUL;
                mcand_d       = op_a;
                mplier_d      = op_b;
                acc_d         = '0;
                cnt_d         = '0;
                mdst_d        = dst_reg;
                issue_ready_d = 1'b0;
            end else
`endif
            if (alu_legal) begin
                commit = 1'b1;
            end else begin
                illegal_d = 1'b1;
            end
        end

`ifdef EXEC_MUL_EN
        if (state_q == ST_MUL) begin
            acc_d    = acc_q + partial;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CW'(MUL_CYCLES - 1)) begin
                state_d    = ST_IDLE;
                commit     = 1'b1;
                commit_res = acc_q + partial;
                commit_c   = 1'b0;
                commit_dst = mdst_q;
            end else begin
                issue_ready_d = 1'b0;
            end
        end
`endif

        // r0 is read-only: flags still follow the result, the write port does not.
        if (commit) begin
            flag_z_d = (commit_res == '0);
            flag_c_d = commit_c;
            if (commit_dst != '0) begin
                wr_en_d   = 1'b1;
                wr_reg_d  = commit_dst;
                wr_data_d = commit_res;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issue_ready_q <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_reg_q      <= '0;
            wr_data_q     <= '0;
            flag_z_q      <= 1'b0;
            flag_c_q      <= 1'b0;
            illegal_q     <= 1'b0;
`ifdef EXEC_MUL_EN
            state_q       <= ST_IDLE;
            mcand_q       <= '0;
            mplier_q      <= '0;
            acc_q         <= '0;
            cnt_q         <= '0;
            mdst_q        <= '0;
`endif
        end else begin
            issue_ready_q <= issue_ready_d;
            wr_en_q       <= wr_en_d;
            wr_reg_q      <= wr_reg_d;
            wr_data_q     <= wr_data_d;
            flag_z_q      <= flag_z_d;
            flag_c_q      <= flag_c_d;
            illegal_q     <= illegal_d;
`ifdef EXEC_MUL_EN
            state_q       <= state_d;
            mcand_q       <= mcand_d;
            mplier_q      <= mplier_d;
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            mdst_q        <= mdst_d;
`endif
        end
    end

    assign issue_ready = issue_ready_q;
    assign wr_en       = wr_en_q;
    assign wr_reg      = wr_reg_q;
    assign wr_data     = wr_data_q;
    assign flag_z      = flag_z_q;
    assign flag_c      = flag_c_q;
    assign illegal     = illegal_q;

endmodule

// File: tb/tb_exec_stage.sv
// Scoreboard bench for exec_stage: stimulus pushes expected writebacks/illegal pulses,
// a negedge monitor pops and compares them, including the cycle each one must appear in.
module tb_exec_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        issue_valid = 1'b0;
    logic        issue_ready;
    logic [3:0]  opcode = 4'd0;
    logic [2:0]  dst_reg = 3'd0;
    logic [15:0] op_a = 16'd0;
    logic [15:0] op_b = 16'd0;
    logic        wr_en;
    logic [2:0]  wr_reg;
    logic [15:0] wr_data;
    logic        flag_z;
    logic        flag_c;
    logic        illegal;

    exec_stage dut (
        .clk        (clk),
        .rst        (rst),
        .issue_valid(issue_valid),
        .issue_ready(issue_ready),
        .opcode     (opcode),
        .dst_reg    (dst_reg),
        .op_a       (op_a),
        .op_b       (op_b),
        .wr_en      (wr_en),
        .wr_reg     (wr_reg),
        .wr_data    (wr_data),
        .flag_z     (flag_z),
        .flag_c     (flag_c),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        bit          ill;
        logic [2:0]  rg;
        logic [15:0] data;
        bit          z;
        bit          c;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    bit          mz = 1'b0;
    bit          mc = 1'b0;
    logic [2:0]  hold_reg = 3'd0;
    logic [15:0] hold_data = 16'd0;

    task automatic chk(input string name, input bit ok, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference behaviour straight from the opcode table, using plain integer arithmetic.
    function automatic void model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                  output bit legal, output logic [15:0] res, output bit c);
        logic [31:0] w;
        legal = 1'b1;
        c     = 1'b0;
        res   = 16'd0;
        w     = 32'd0;
        case (op)
            4'd0: begin w = 32'(a) + 32'(b); res = w[15:0]; c = (w > 32'h0000FFFF); end
            4'd1: begin res = 16'(32'(a) + 32'h10000 - 32'(b)); c = (a < b); end
            4'd2: res = a & b;
            4'd3: res = a | b;
            4'd4: res = a ^ b;
            4'd5: begin w = 32'(a) * (32'd1 << b[3:0]); res = w[15:0]; end
            4'd6: res = 16'(32'(a) / (32'd1 << b[3:0]));
            4'd7: begin
`ifdef EXEC_MUL_EN
                w = 32'(a) * 32'(b);
                res = w[15:0];
`else
                legal = 1'b0;
`endif
            end
            4'd8: res = b;
            default: legal = 1'b0;
        endcase
    endfunction

    task automatic issue(input logic [3:0] op, input logic [2:0] d, input logic [15:0] a,
                         input logic [15:0] b, output int waits);
        bit          acc;
        bit          legal;
        bit          c;
        logic [15:0] res;
        exp_t        e;
        int          lat;
        acc   = 1'b0;
        waits = 0;
        for (int t = 0; t < 64 && !acc; t++) begin
            @(negedge clk);
            issue_valid = 1'b1;
            opcode      = op;
            dst_reg     = d;
            op_a        = a;
            op_b        = b;
            if (issue_ready) acc = 1'b1;
            else waits++;
        end
        chk("issue_accept", acc, 32'(acc), 1);
        if (!acc) return;
        model(op, a, b, legal, res, c);
        lat   = (op == 4'd7 && legal) ? 16 : 0;
        e.due = cyc + 1 + lat;
        if (!legal) begin
            e.ill = 1'b1; e.rg = 3'd0; e.data = 16'd0; e.z = mz; e.c = mc;
            exp_q.push_back(e);
        end else begin
            mz = (res == 16'd0);
            mc = c;
            if (d != 3'd0) begin
                e.ill = 1'b0; e.rg = d; e.data = res; e.z = mz; e.c = mc;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            issue_valid = 1'b0;
        end
    endtask

    function automatic logic [15:0] rnd16();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h0001;
            default: return 16'($urandom);
        endcase
    endfunction

    // Monitor: every wr_en/illegal pulse must match the oldest expected response.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst) begin
            exp_q.delete();
            hold_reg  = 3'd0;
            hold_data = 16'd0;
        end else begin
            if (!wr_en)
                chk("wr_hold", wr_reg == hold_reg && wr_data == hold_data,
                    {13'd0, wr_reg, wr_data}, {13'd0, hold_reg, hold_data});
            if (wr_en || illegal) begin
                chk("event_expected", exp_q.size() != 0, {30'd0, wr_en, illegal}, 32'(exp_q.size()));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("event_cycle", cyc == e.due, cyc, e.due);
                    chk("event_kind", illegal == e.ill && wr_en == !e.ill,
                        {30'd0, wr_en, illegal}, {30'd0, !e.ill, e.ill});
                    chk("flags", flag_z == e.z && flag_c == e.c,
                        {30'd0, flag_z, flag_c}, {30'd0, e.z, e.c});
                    if (!e.ill) begin
                        chk("wr_reg", wr_reg == e.rg, 32'(wr_reg), 32'(e.rg));
                        chk("wr_data", wr_data == e.data, 32'(wr_data), 32'(e.data));
                        hold_reg  = e.rg;
                        hold_data = e.data;
                    end
                end
            end else if (exp_q.size() != 0) begin
                chk("event_late", exp_q[0].due >= cyc, cyc, exp_q[0].due);
                if (exp_q[0].due < cyc) void'(exp_q.pop_front());
            end
        end
    end

    initial begin : stim
        int w;
        logic [3:0] op;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_en", wr_en == 1'b0, 32'(wr_en), 0);
        chk("rst_wr_reg", wr_reg == 3'd0, 32'(wr_reg), 0);
        chk("rst_wr_data", wr_data == 16'd0, 32'(wr_data), 0);
        chk("rst_flags", {flag_z, flag_c} == 2'b00, {30'd0, flag_z, flag_c}, 0);
        chk("rst_illegal", illegal == 1'b0, 32'(illegal), 0);
        chk("rst_ready", issue_ready == 1'b0, 32'(issue_ready), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", issue_ready == 1'b1, 32'(issue_ready), 1);

        // Back-to-back ADD then SUB, both with carry/borrow.
        issue(4'd0, 3'd1, 16'hFFFF, 16'h0001, w);
        issue(4'd1, 3'd4, 16'h0002, 16'h0003, w);
        chk("b2b_no_stall", w == 0, 32'(w), 0);

        // Shifts use only b[3:0].
        issue(4'd5, 3'd3, 16'h0001, 16'hFFF4, w);
        issue(4'd6, 3'd5, 16'h8000, 16'h000F, w);

        // r0 write suppressed but flags follow; illegal leaves flags alone.
        issue(4'd0, 3'd1, 16'hFFFF, 16'h0001, w);
        issue(4'd8, 3'd0, 16'h0000, 16'h1234, w);
        issue(4'd12, 3'd6, 16'h1111, 16'h2222, w);
        idle(2);

`ifdef EXEC_MUL_EN
        issue(4'd7, 3'd7, 16'h0123, 16'h0100, w);
        issue(4'd8, 3'd5, 16'h0000, 16'h00AB, w);
        chk("mul_stall_cycles", w == 16, 32'(w), 16);
`else
        issue(4'd7, 3'd3, 16'h0005, 16'h0006, w);
        issue(4'd8, 3'd5, 16'h0000, 16'h00AB, w);
        chk("op7_ready_stays", w == 0, 32'(w), 0);
`endif
        idle(2);

        // Reset while opcode 7 is in flight: nothing from it may ever be written back.
        issue(4'd0, 3'd3, 16'hFFFF, 16'h0002, w);
        issue(4'd7, 3'd2, 16'h0003, 16'h0005, w);
        idle(4);
        #2;
        rst = 1'b0;
        mz  = 1'b0;
        mc  = 1'b0;
        #1;
        chk("abort_wr_en", wr_en == 1'b0, 32'(wr_en), 0);
        chk("abort_wr_data", {wr_reg, wr_data} == 19'd0, {13'd0, wr_reg, wr_data}, 0);
        chk("abort_flags", {flag_z, flag_c, illegal} == 3'd0, {29'd0, flag_z, flag_c, illegal}, 0);
        chk("abort_ready", issue_ready == 1'b0, 32'(issue_ready), 0);
        repeat (3) begin
            @(negedge clk);
            chk("rst_low_wr_en", wr_en == 1'b0, 32'(wr_en), 0);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_rerst", issue_ready == 1'b1, 32'(issue_ready), 1);
        idle(20);

        // Randomized traffic with idle gaps, r0 destinations and illegal opcodes.
        for (int i = 0; i < 300; i++) begin
            op = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) op = 4'($urandom_range(0, 8));
            issue(op, 3'($urandom_range(0, 7)), rnd16(), rnd16(), w);
            if ($urandom_range(0, 4) == 0) idle(int'($urandom_range(1, 3)));
        end
        idle(1);
        for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(negedge clk);
        chk("drain", exp_q.size() == 0, 32'(exp_q.size()), 0);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
